// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, reads the synchronous instruction memory
// and presents each instruction to the control unit with a valid flag.
module instruction_fetch_unit #(
  parameter int          ADDR_W  = 8,
  parameter int          INSTR_W = 16,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fetch_req,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_rd_en,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic [INSTR_W-1:0] instruction_register,
  output logic               ir_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               halted
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH1,
    FETCH2,
    READY,
    HALT
  } state_t;

  state_t               state_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [ADDR_W-1:0]    mem_addr_q;
  logic                 mem_rd_en_q;
  logic [INSTR_W-1:0]   ir_q;
  logic                 ir_valid_q;
  logic                 halted_q;
  logic [ADDR_W-1:0]    tgt_d;
  logic                 is_halt_d;

  // A jump sampled together with a fetch start redirects that fetch.
  assign tgt_d     = jump_en ? jump_addr : pc_q;
  assign is_halt_d = (mem_rdata[3:0] == HALT_OP);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      mem_addr_q  <= '0;
      mem_rd_en_q <= 1'b0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      mem_rd_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (jump_en) pc_q <= jump_addr;
          if (start) begin
            state_q     <= FETCH1;
            mem_addr_q  <= tgt_d;
            mem_rd_en_q <= 1'b1;
            ir_valid_q  <= 1'b0;
          end
        end
        FETCH1: begin
          state_q <= FETCH2;
        end
        FETCH2: begin
          ir_q       <= mem_rdata;
          ir_valid_q <= 1'b1;
          pc_q       <= pc_q + 1'b1;
          if (is_halt_d) begin
            state_q  <= HALT;
            halted_q <= 1'b1;
          end else begin
            state_q  <= READY;
          end
        end
        READY: begin
          if (jump_en) pc_q <= jump_addr;
          if (start && fetch_req) begin
            state_q     <= FETCH1;
            mem_addr_q  <= tgt_d;
            mem_rd_en_q <= 1'b1;
            ir_valid_q  <= 1'b0;
          end
        end
        HALT: begin
          state_q <= HALT;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_addr             = mem_addr_q;
  assign mem_rd_en            = mem_rd_en_q;
  assign instruction_register = ir_q;
  assign ir_valid             = ir_valid_q;
  assign pc                   = pc_q;
  assign halted               = halted_q;

endmodule
